pe_feed_ctrl: RTL and testbench
===============================

PE_FEED_CTRL -- requirements
Module: pe_feed_ctrl

Interface
REQ-001 Parameter SIZE, default 8: data width of the PE operands and result.
REQ-002 Parameter L_RAM_SIZE, default 3: log2 of the PE local RAM depth; vector length N = 2**L_RAM_SIZE.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles allowed in CALC_WAIT before an error abort.
REQ-004 aclk  in  1  single clock; all state changes on rising edge.
REQ-005 aresetn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to run one dot-product job; sampled only in IDLE.
REQ-007 busy  out  1  high whenever state is not IDLE.
REQ-008 done  out  1  one-cycle pulse at job end.
REQ-009 err  out  1  set with done when the job aborted on timeout; held until the next accepted start.
REQ-010 result  out  SIZE  PE dout captured at job end; held until the next capture.
REQ-011 src_addr  out  L_RAM_SIZE+1  read address into the source buffer; din vector at 0..N-1, ain vector at N..2N-1.
REQ-012 src_data  in  SIZE  source buffer read data, valid exactly one cycle after src_addr.
REQ-013 pe_addr  out  L_RAM_SIZE  PE local RAM address.
REQ-014 pe_we  out  1  PE RAM write enable.
REQ-015 pe_din  out  SIZE  PE RAM write data.
REQ-016 pe_ain  out  SIZE  PE streaming operand.
REQ-017 pe_valid  out  1  one-cycle pulse: PE multiplies pe_ain by RAM[pe_addr] and accumulates.
REQ-018 pe_dvalid  in  1  PE pulse: accumulation for the last pe_valid is complete.
REQ-019 pe_dout  in  SIZE  PE accumulated result.

Function
REQ-020 States SHALL be IDLE, LOAD, CALC_RD, CALC_FEED, CALC_WAIT, DONE.
REQ-021 IDLE: on start=1, clear err, clear element counter k, go to LOAD next cycle; otherwise stay.
REQ-022 LOAD SHALL last N+1 cycles: cycle j (0..N-1) drives src_addr=j; cycle j+1 drives pe_we=1, pe_addr=j, pe_din=src_data; then go to CALC_RD.
REQ-023 CALC_RD (1 cycle): src_addr=N+k, pe_we=0.
REQ-024 CALC_FEED (1 cycle): pe_ain=src_data, pe_addr=k, pe_valid=1.
REQ-025 CALC_WAIT: pe_valid=0, pe_addr and pe_ain held; watchdog counts cycles spent in the state.
REQ-026 CALC_WAIT exit: pe_dvalid=1 with k<N-1 -> k+1, CALC_RD; pe_dvalid=1 with k=N-1 -> DONE.
REQ-027 Watchdog reaching TIMEOUT without pe_dvalid -> err=1, DONE; pe_dvalid on the same cycle as expiry wins (no error).
REQ-028 DONE (1 cycle): result<=pe_dout, done=1, then IDLE.
REQ-029 pe_dvalid outside CALC_WAIT SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-030 pe_we and pe_valid SHALL never be high in the same cycle.
REQ-031 k and src_addr SHALL not wrap within a job; the counter width is exactly sufficient for N-1 and 2N-1.
REQ-032 Per-element cost SHALL be 2+L cycles for PE latency L (L>=1, pe_dvalid L cycles after pe_valid).

Reset
REQ-033 aresetn low SHALL immediately force IDLE and set busy, done, err, pe_we, pe_valid to 0 and result, src_addr, pe_addr, pe_din, pe_ain, k, and watchdog to 0.
REQ-034 Reset mid-job SHALL abandon the job without a done pulse; the first start after release runs a full job from LOAD.

Structure
REQ-035 Package pe_feed_pkg SHALL hold the state enumeration and the TIMEOUT default.
REQ-036 The watchdog SHALL be sub-module pe_timeout_cnt (clear, enable, expired); all other logic is in pe_feed_ctrl.

Verification
REQ-037 din=1..8, ain all 1, PE model L=3, start at cycle 0 -> LOAD cycles 1..9, done at cycle 50, result=36, err=0.
REQ-038 LOAD trace check -> pe_we high for exactly 8 cycles, pe_addr 0..7 paired with din 1..8, no pe_valid overlap.
REQ-039 PE model never returns dvalid on element 3 -> err=1 with done after 64 cycles in CALC_WAIT; err cleared on the next start.
REQ-040 start pulsed during CALC_WAIT and a spurious pe_dvalid in CALC_RD -> ignored; result and timing are identical to REQ-037.
REQ-041 aresetn low during element 5, then start -> no done from the aborted job; second job gives result=36.
REQ-042 din all 0xFF, ain all 0x02, L=1 -> done at cycle 34; result equals the model's 8-bit wrapped dout (0xF0).

Source files
------------

// File: rtl/pe_feed_pkg.sv
// Shared definitions for the PE feed controller: FSM state encoding,
// the default watchdog limit and a counter-width helper.
package pe_feed_pkg;

  // Default number of cycles tolerated in CALC_WAIT before aborting a job
  localparam int TIMEOUT_DFLT = 64;

  // Controller states; the encoding is kept explicit so traces stay readable
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    CALC_RD   = 3'd2,
    CALC_FEED = 3'd3,
    CALC_WAIT = 3'd4,
    DONE      = 3'd5
  } feed_state_e;

  // Number of bits needed to hold values 0..max_val (never less than one)
  function automatic int bits_for(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/pe_timeout_cnt.sv
// Watchdog for the CALC_WAIT state: counts enabled cycles since the last
// clear and flags the cycle in which the TIMEOUT-th enabled cycle is reached.
module pe_timeout_cnt
  import pe_feed_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DFLT
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = bits_for(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Count enabled cycles, restart on clear, saturate at the last value
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && (cnt_r != CNT_LAST)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The count is zero in the first enabled cycle, so reaching CNT_LAST
  // marks the TIMEOUT-th cycle spent waiting.
  assign expired = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/pe_feed_ctrl.sv
// Dot-product feed controller: loads the din vector into the PE local RAM,
// then streams the ain vector one element at a time, waiting for the PE to
// acknowledge each accumulation before feeding the next one.
module pe_feed_ctrl
  import pe_feed_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int L_RAM_SIZE = 3,
  parameter int TIMEOUT    = TIMEOUT_DFLT
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SIZE-1:0]       result,
  output logic [L_RAM_SIZE:0]   src_addr,
  input  logic [SIZE-1:0]       src_data,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic [SIZE-1:0]       pe_din,
  output logic [SIZE-1:0]       pe_ain,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [SIZE-1:0]       pe_dout
);

  localparam int N  = 1 << L_RAM_SIZE;
  localparam int AW = L_RAM_SIZE + 1;

  localparam logic [AW-1:0]         LD_LAST = AW'(N);
  localparam logic [AW-1:0]         LD_ONE  = AW'(1);
  localparam logic [L_RAM_SIZE-1:0] K_LAST  = L_RAM_SIZE'(N - 1);
  localparam logic [L_RAM_SIZE-1:0] K_ONE   = L_RAM_SIZE'(1);

  feed_state_e           state_r;
  logic [AW-1:0]         ld_cnt_r;     // LOAD cycle index 0..N
  logic [L_RAM_SIZE-1:0] k_r;          // element currently being fed
  logic [L_RAM_SIZE-1:0] k_next_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic [SIZE-1:0]       result_r;
  logic [AW-1:0]         src_addr_r;
  logic [L_RAM_SIZE-1:0] pe_addr_r;
  logic                  pe_we_r;
  logic                  pe_valid_r;
  logic [SIZE-1:0]       ain_hold_r;   // operand kept stable while the PE works
  logic                  wd_clear_s;
  logic                  wd_enable_s;
  logic                  wd_expired_s;

  assign k_next_s    = k_r + K_ONE;
  assign wd_enable_s = (state_r == CALC_WAIT);
  assign wd_clear_s  = ~wd_enable_s;

  pe_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // Job sequencing FSM; every output register is set on the transition into
  // the state that owns it so it is valid for that whole state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= IDLE;
      ld_cnt_r   <= {AW{1'b0}};
      k_r        <= {L_RAM_SIZE{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      result_r   <= {SIZE{1'b0}};
      src_addr_r <= {AW{1'b0}};
      pe_addr_r  <= {L_RAM_SIZE{1'b0}};
      pe_we_r    <= 1'b0;
      pe_valid_r <= 1'b0;
      ain_hold_r <= {SIZE{1'b0}};
    end else begin
      // Single-cycle strobes drop unless a transition below raises them
      done_r     <= 1'b0;
      pe_we_r    <= 1'b0;
      pe_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= LOAD;
            busy_r     <= 1'b1;
            err_r      <= 1'b0;
            k_r        <= {L_RAM_SIZE{1'b0}};
            ld_cnt_r   <= {AW{1'b0}};
            src_addr_r <= {AW{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end

        LOAD: begin
          if (ld_cnt_r == LD_LAST) begin
            // Last din element has just been written; fetch ain[k]
            state_r    <= CALC_RD;
            src_addr_r <= {1'b1, k_r};
          end else begin
            // Read data for address ld_cnt_r arrives next cycle: write it then
            state_r    <= LOAD;
            ld_cnt_r   <= ld_cnt_r + LD_ONE;
            pe_we_r    <= 1'b1;
            pe_addr_r  <= ld_cnt_r[L_RAM_SIZE-1:0];
            src_addr_r <= ld_cnt_r + LD_ONE;
          end
        end

        CALC_RD: begin
          state_r    <= CALC_FEED;
          pe_valid_r <= 1'b1;
          pe_addr_r  <= k_r;
        end

        CALC_FEED: begin
          state_r    <= CALC_WAIT;
          ain_hold_r <= src_data;
        end

        CALC_WAIT: begin
          if (pe_dvalid) begin
            if (k_r == K_LAST) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= pe_dout;
            end else begin
              state_r    <= CALC_RD;
              k_r        <= k_next_s;
              src_addr_r <= {1'b1, k_next_s};
            end
          end else if (wd_expired_s) begin
            state_r  <= DONE;
            done_r   <= 1'b1;
            err_r    <= 1'b1;
            result_r <= pe_dout;
          end else begin
            state_r <= CALC_WAIT;
          end
        end

        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign result   = result_r;
  assign src_addr = src_addr_r;
  assign pe_addr  = pe_addr_r;
  assign pe_we    = pe_we_r;
  assign pe_valid = pe_valid_r;

  // The source buffer answers one cycle after the address, so write data and
  // the fed operand come straight from src_data in the cycle they are used.
  assign pe_din = pe_we_r ? src_data : {SIZE{1'b0}};
  assign pe_ain = (state_r == CALC_FEED) ? src_data : ain_hold_r;

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Bench for pe_feed_ctrl: a source buffer and PE model drive the DUT, jobs
// push their expected outcome into a scoreboard and a monitor checks each
// done pulse against it.
`timescale 1ns/1ps
module tb_pe_feed_ctrl;

  localparam int N  = 8;
  localparam int TO = 64;

  logic       aclk      = 1'b0;
  logic       aresetn   = 1'b1;
  logic       start     = 1'b0;
  logic       busy, done, err;
  logic [7:0] result;
  logic [3:0] src_addr;
  logic [7:0] src_data  = 8'd0;
  logic [2:0] pe_addr;
  logic       pe_we;
  logic [7:0] pe_din, pe_ain;
  logic       pe_valid;
  logic       pe_dvalid = 1'b0;
  logic [7:0] pe_dout   = 8'd0;

  pe_feed_ctrl #(.SIZE(8), .L_RAM_SIZE(3), .TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
    .err(err), .result(result), .src_addr(src_addr), .src_data(src_data),
    .pe_addr(pe_addr), .pe_we(pe_we), .pe_din(pe_din), .pe_ain(pe_ain),
    .pe_valid(pe_valid), .pe_dvalid(pe_dvalid), .pe_dout(pe_dout)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] res;
    logic       e;
    int         dc;
  } exp_t;
  exp_t sb_q[$];

  // Job data and environment state
  logic [7:0] src_mem [0:15];
  logic [7:0] cur_din [0:7];
  logic [7:0] cur_ain [0:7];
  logic [7:0] pe_ram  [0:7];
  int         pe_lat      = 3;
  int         stuck_elem  = N;
  bit         spur[int];
  bit         start_issue = 1'b0;
  logic [7:0] acc = 8'd0, acc_next = 8'd0;
  int         dv_at = -1;
  int         widx = 0, vidx = 0;
  logic [3:0] addr_prev = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source buffer and PE model: inputs change #1 after the edge, outputs are
  // observed on the falling edge.
  initial begin : env
    forever begin
      @(posedge aclk); #1;
      src_data = src_mem[addr_prev];
      if (cyc == dv_at) begin
        acc       = acc_next;
        pe_dvalid = 1'b1;
        dv_at     = -1;
      end else begin
        pe_dvalid = spur.exists(cyc) ? 1'b1 : 1'b0;
      end
      pe_dout = acc;
      @(negedge aclk);
      addr_prev = src_addr;
      if (start_issue) begin
        widx = 0; vidx = 0; acc = 8'd0; acc_next = 8'd0; dv_at = -1;
        start_issue = 1'b0;
      end
      if (!aresetn) begin
        dv_at = -1;
      end else begin
        if (pe_we) begin
          if (widx < N) begin
            check("load_addr", pe_addr, widx);
            check("load_din", pe_din, cur_din[widx]);
            pe_ram[pe_addr] = pe_din;
          end else begin
            check("load_extra_write", widx, N - 1);
          end
          widx++;
        end
        if (pe_valid) begin
          if (vidx < N) begin
            check("feed_addr", pe_addr, vidx);
            check("feed_ain", pe_ain, cur_ain[vidx]);
          end
          if (vidx != stuck_elem) begin
            acc_next = acc + pe_ain * pe_ram[pe_addr];
            dv_at    = cyc + pe_lat;
          end
          vidx++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (pe_we || pe_valid) check("we_valid_exclusive", {31'd0, pe_we & pe_valid}, 32'd0);
        if (done) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
          end else begin
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("err", err, e.e);
            check("done_cycle", cyc, e.dc);
            check("busy_at_done", busy, 1);
            check("load_write_count", widx, N);
          end
        end
      end
    end
  end

  task automatic do_reset();
    aresetn = 1'b0;
    sb_q.delete();
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pe_we", pe_we, 0);
    check("rst_pe_valid", pe_valid, 0);
    check("rst_result", result, 0);
    check("rst_src_addr", src_addr, 0);
    check("rst_pe_addr", pe_addr, 0);
    check("rst_pe_din", pe_din, 0);
    check("rst_pe_ain", pe_ain, 0);
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  // Issue one job; rst_off >= 0 aborts it with a reset that many cycles after start
  task automatic run_job(input int lat, input int stuck, input bit noise, input int rst_off);
    int s, dc, lim, rd0;
    logic [7:0] sum;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      src_mem[i]     = cur_din[i];
      src_mem[N + i] = cur_ain[i];
    end
    pe_lat     = lat;
    stuck_elem = stuck;
    lim = (stuck < N) ? stuck : N;
    sum = 8'd0;
    for (int i = 0; i < lim; i++) sum = sum + cur_din[i] * cur_ain[i];
    s   = cyc;
    rd0 = s + N + 2;
    dc  = rd0 + lim * (2 + lat) + ((stuck < N) ? (2 + TO) : 0);
    if (noise) begin
      spur[s + 3] = 1'b1;
      for (int i = 0; i < lim; i++) spur[rd0 + i * (2 + lat)] = 1'b1;
    end
    e.res = sum; e.e = (stuck < N); e.dc = dc;
    if (rst_off < 0) sb_q.push_back(e);
    start = 1'b1; start_issue = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_clear_on_start", err, 0);
    while (cyc < dc + 2) begin
      if (rst_off >= 0 && cyc == s + rst_off) begin
        do_reset();
        return;
      end
      start = 1'b0;
      if (noise) begin
        for (int i = 0; i < lim; i++) if (cyc == rd0 + i * (2 + lat) + 2) start = 1'b1;
      end
      @(posedge aclk); #1;
    end
    start = 1'b0;
    if (rst_off < 0) begin
      check("job_completed", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) begin
      cur_din[i] = 8'(i + 1);
      cur_ain[i] = 8'd1;
    end
  endtask

  initial begin : main
    for (int i = 0; i < 16; i++) src_mem[i] = 8'd0;
    set_ramp();
    #2;
    do_reset();

    // Basic job: 1..8 dot all-ones, PE latency 3
    run_job(3, N, 1'b0, -1);

    // Element 3 never acknowledged: watchdog abort, err and result held afterwards
    run_job(3, 3, 1'b0, -1);
    repeat (3) @(posedge aclk);
    #1;
    check("err_held", err, 1);
    check("result_held", result, 8'd6);

    // Stray start pulses and stray dvalid must not disturb the job
    run_job(3, N, 1'b1, -1);

    // Wrapping accumulation with the shortest PE latency
    for (int i = 0; i < N; i++) begin
      cur_din[i] = 8'hFF;
      cur_ain[i] = 8'h02;
    end
    run_job(1, N, 1'b0, -1);

    // Reset during element 5, then a clean job
    set_ramp();
    run_job(3, N, 1'b0, 37);
    run_job(3, N, 1'b0, -1);

    // dvalid in the same cycle the watchdog expires: no error
    run_job(TO, N, 1'b0, -1);

    // Randomized jobs
    for (int j = 0; j < 15; j++) begin
      for (int i = 0; i < N; i++) begin
        cur_din[i] = 8'($urandom);
        cur_ain[i] = 8'($urandom);
      end
      run_job($urandom_range(1, 5),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : N,
              1'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 2)) @(posedge aclk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
